// File: rtl/hazard_tracker.sv
// hazard_tracker: stall and bypass control for a five-stage MIPS-style pipeline.
// The E, M and W stages are tracked only by the register they will write and
// the number of cycles until that result exists (Tnew). The D stage gives, for
// each source register, the cycle in which the value is first needed (Tuse).
// A hazard that no bypass can cover holds D and puts a bubble into E. Every
// other match is handled by one of the bypass selects.
module hazard_tracker (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] A1D,
  input  logic [4:0] A2D,
  input  logic [4:0] A3D,
  input  logic [1:0] resOpD,
  input  logic       Tuse_rs0,
  input  logic       Tuse_rs1,
  input  logic       Tuse_rt0,
  input  logic       Tuse_rt1,
  input  logic       Tuse_rt2,
  output logic       stall,
  output logic       flushE,
  output logic [1:0] fwdRsD,
  output logic [1:0] fwdRtD,
  output logic [1:0] fwdRsE,
  output logic [1:0] fwdRtE,
  output logic       fwdRtM
);

  localparam logic [1:0] RES_NW  = 2'd0;
  localparam logic [1:0] RES_ALU = 2'd1;
  localparam logic [1:0] RES_DM  = 2'd2;
  localparam logic [1:0] RES_PC  = 2'd3;

  // Stage records
  logic [4:0] a1_e, a2_e, a3_e;
  logic [1:0] tnew_e;
  logic [4:0] a2_m, a3_m;
  logic [1:0] tnew_m;
  logic [4:0] a3_w;

  logic [1:0] tnew_d;
  logic [4:0] a3_d;
  logic       use_rs, use_rt;
  logic [1:0] tuse_rs, tuse_rt;
  logic       stall_rs, stall_rt, stall_raw;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic       fwd_rt_m;

  // Derive the Tnew and destination that the D instruction carries into E
  always_comb begin
    tnew_d = 2'd0;
    a3_d   = A3D;
    case (resOpD)
      RES_ALU: tnew_d = 2'd1;
      RES_DM:  tnew_d = 2'd2;
      RES_PC:  tnew_d = 2'd0;
      RES_NW:  a3_d   = 5'd0;
      default: tnew_d = 2'd0;
    endcase
  end

  // Decode the one-hot-ish Tuse inputs; the earliest need wins
  always_comb begin
    use_rs  = Tuse_rs0 | Tuse_rs1;
    tuse_rs = Tuse_rs0 ? 2'd0 : 2'd1;
    use_rt  = Tuse_rt0 | Tuse_rt1 | Tuse_rt2;
    tuse_rt = Tuse_rt0 ? 2'd0 : (Tuse_rt1 ? 2'd1 : 2'd2);
  end

  // Stall when a producer in E or M cannot deliver before the consumer needs it
  always_comb begin
    stall_rs = use_rs && (A1D != 5'd0) &&
               (((A1D == a3_e) && (tuse_rs < tnew_e)) ||
                ((A1D == a3_m) && (tuse_rs < tnew_m)));
    stall_rt = use_rt && (A2D != 5'd0) &&
               (((A2D == a3_e) && (tuse_rt < tnew_e)) ||
                ((A2D == a3_m) && (tuse_rt < tnew_m)));
    stall_raw = stall_rs | stall_rt;
  end

  // Bypass selects; a nearer stage always beats a farther one
  always_comb begin
    fwd_rs_d = 2'b00;
    if ((A1D != 5'd0) && (A1D == a3_e) && (tnew_e == 2'd0))      fwd_rs_d = 2'b01;
    else if ((A1D != 5'd0) && (A1D == a3_m) && (tnew_m == 2'd0)) fwd_rs_d = 2'b10;

    fwd_rt_d = 2'b00;
    if ((A2D != 5'd0) && (A2D == a3_e) && (tnew_e == 2'd0))      fwd_rt_d = 2'b01;
    else if ((A2D != 5'd0) && (A2D == a3_m) && (tnew_m == 2'd0)) fwd_rt_d = 2'b10;

    fwd_rs_e = 2'b00;
    if ((a1_e != 5'd0) && (a1_e == a3_m) && (tnew_m == 2'd0)) fwd_rs_e = 2'b01;
    else if ((a1_e != 5'd0) && (a1_e == a3_w))                fwd_rs_e = 2'b10;

    fwd_rt_e = 2'b00;
    if ((a2_e != 5'd0) && (a2_e == a3_m) && (tnew_m == 2'd0)) fwd_rt_e = 2'b01;
    else if ((a2_e != 5'd0) && (a2_e == a3_w))                fwd_rt_e = 2'b10;

    fwd_rt_m = (a2_m != 5'd0) && (a2_m == a3_w);
  end

  // Outputs read zero while reset is held, even before the first reset edge
  always_comb begin
    stall  = stall_raw & ~reset;
    flushE = stall_raw & ~reset;
    fwdRsD = reset ? 2'b00 : fwd_rs_d;
    fwdRtD = reset ? 2'b00 : fwd_rt_d;
    fwdRsE = reset ? 2'b00 : fwd_rs_e;
    fwdRtE = reset ? 2'b00 : fwd_rt_e;
    fwdRtM = fwd_rt_m & ~reset;
  end

  // Advance the stage records; a stall turns E into a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      a1_e   <= 5'd0;
      a2_e   <= 5'd0;
      a3_e   <= 5'd0;
      tnew_e <= 2'd0;
      a2_m   <= 5'd0;
      a3_m   <= 5'd0;
      tnew_m <= 2'd0;
      a3_w   <= 5'd0;
    end else begin
      if (stall_raw) begin
        a1_e   <= 5'd0;
        a2_e   <= 5'd0;
        a3_e   <= 5'd0;
        tnew_e <= 2'd0;
      end else begin
        a1_e   <= A1D;
        a2_e   <= A2D;
        a3_e   <= a3_d;
        tnew_e <= tnew_d;
      end
      a2_m   <= a2_e;
      a3_m   <= a3_e;
      tnew_m <= (tnew_e != 2'd0) ? tnew_e - 2'd1 : 2'd0;
      a3_w   <= a3_m;
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: instruction sequences with hand-derived
// stall and bypass expectations, checked half a cycle after inputs change.
module tb_hazard_tracker;

  logic       clk;
  logic       reset;
  logic [4:0] A1D, A2D, A3D;
  logic [1:0] resOpD;
  logic       Tuse_rs0, Tuse_rs1, Tuse_rt0, Tuse_rt1, Tuse_rt2;
  logic       stall, flushE;
  logic [1:0] fwdRsD, fwdRtD, fwdRsE, fwdRtE;
  logic       fwdRtM;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] NW = 2'd0, ALU = 2'd1, DM = 2'd2, PC = 2'd3;

  hazard_tracker dut (
    .clk(clk), .reset(reset),
    .A1D(A1D), .A2D(A2D), .A3D(A3D), .resOpD(resOpD),
    .Tuse_rs0(Tuse_rs0), .Tuse_rs1(Tuse_rs1),
    .Tuse_rt0(Tuse_rt0), .Tuse_rt1(Tuse_rt1), .Tuse_rt2(Tuse_rt2),
    .stall(stall), .flushE(flushE),
    .fwdRsD(fwdRsD), .fwdRtD(fwdRtD),
    .fwdRsE(fwdRsE), .fwdRtE(fwdRtE),
    .fwdRtM(fwdRtM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rs_use = {Tuse_rs1, Tuse_rs0}, rt_use = {Tuse_rt2, Tuse_rt1, Tuse_rt0}
  task automatic set_d(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                       input logic [1:0] res, input logic [1:0] rs_use, input logic [2:0] rt_use);
    A1D = a1; A2D = a2; A3D = a3; resOpD = res;
    Tuse_rs0 = rs_use[0]; Tuse_rs1 = rs_use[1];
    Tuse_rt0 = rt_use[0]; Tuse_rt1 = rt_use[1]; Tuse_rt2 = rt_use[2];
  endtask

  task automatic nop_d();
    set_d(5'd0, 5'd0, 5'd0, NW, 2'b00, 3'b000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop_d();
    repeat (3) tick();
  endtask

  task automatic chk(input string tag, input string sig, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s.%s: observed %0d expected %0d", tag, sig, got, exp);
    end
  endtask

  // Waits for the falling edge, then compares every output
  task automatic chk_all(input string tag, input logic exp_stall,
                         input logic [1:0] e_rsd, input logic [1:0] e_rtd,
                         input logic [1:0] e_rse, input logic [1:0] e_rte, input logic e_rtm);
    @(negedge clk);
    chk(tag, "stall",  {1'b0, stall},  {1'b0, exp_stall});
    chk(tag, "flushE", {1'b0, flushE}, {1'b0, exp_stall});
    chk(tag, "fwdRsD", fwdRsD, e_rsd);
    chk(tag, "fwdRtD", fwdRtD, e_rtd);
    chk(tag, "fwdRsE", fwdRsE, e_rse);
    chk(tag, "fwdRtE", fwdRtE, e_rte);
    chk(tag, "fwdRtM", {1'b0, fwdRtM}, {1'b0, e_rtm});
  endtask

  initial begin
    reset = 1'b1;
    nop_d();

    // Reset held two cycles with random D inputs
    for (int i = 0; i < 2; i++) begin
      set_d(5'($urandom), 5'($urandom), 5'($urandom), 2'($urandom),
            2'($urandom), 3'($urandom));
      chk_all("reset_hold", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
      tick();
    end
    reset = 1'b0;
    nop_d();
    chk_all("post_reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();

    // lw $2 ; addu $6,$2,$3 : one stall, then W->E bypass on rs
    drain();
    set_d(5'd0, 5'd0, 5'd2, DM, 2'b00, 3'b000);
    chk_all("lw2", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    set_d(5'd2, 5'd3, 5'd6, ALU, 2'b10, 3'b010);
    chk_all("addu_stall", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    chk_all("addu_go", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    nop_d();
    chk_all("addu_in_e", 1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0);
    tick();

    // lw $4 ; beq rt=$4 : two stalls, then read through the register file
    drain();
    set_d(5'd0, 5'd0, 5'd4, DM, 2'b00, 3'b000);
    chk_all("lw4", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    set_d(5'd0, 5'd4, 5'd0, NW, 2'b00, 3'b001);
    chk_all("beq_stall1", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    chk_all("beq_stall2", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    chk_all("beq_grf", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();

    // addu $5 ; beq rs=$5 : one stall, then M->D bypass
    drain();
    set_d(5'd8, 5'd9, 5'd5, ALU, 2'b10, 3'b010);
    chk_all("addu5", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    set_d(5'd5, 5'd0, 5'd0, NW, 2'b01, 3'b000);
    chk_all("beq5_stall", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    chk_all("beq5_fwd", 1'b0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();

    // jal ; jr $31 : no stall, E->D bypass
    drain();
    set_d(5'd0, 5'd0, 5'd31, PC, 2'b00, 3'b000);
    chk_all("jal", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    set_d(5'd31, 5'd0, 5'd0, NW, 2'b01, 3'b000);
    chk_all("jr", 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();

    // jal ; jal ; jr $31 : both E and M match, E wins
    drain();
    set_d(5'd0, 5'd0, 5'd31, PC, 2'b00, 3'b000);
    tick();
    tick();
    set_d(5'd31, 5'd0, 5'd0, NW, 2'b01, 3'b000);
    chk_all("jr_prio", 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();

    // lw $0 ; addu rs=$0 : register zero never stalls or forwards
    drain();
    set_d(5'd0, 5'd0, 5'd0, DM, 2'b00, 3'b000);
    tick();
    set_d(5'd0, 5'd0, 5'd10, ALU, 2'b10, 3'b010);
    chk_all("zero_d", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    nop_d();
    chk_all("zero_e", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();

    // addu $7 ; sw rt=$7 : no stall, M->E then W->M store-data bypass
    drain();
    set_d(5'd8, 5'd9, 5'd7, ALU, 2'b10, 3'b010);
    tick();
    set_d(5'd29, 5'd7, 5'd0, NW, 2'b10, 3'b100);
    chk_all("sw_d", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    nop_d();
    chk_all("sw_e", 1'b0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b0);
    tick();
    chk_all("sw_m", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
    tick();

    // addu $11 ; addu $11 ; addu rs=$11 : M beats W in E
    drain();
    set_d(5'd0, 5'd0, 5'd11, ALU, 2'b00, 3'b000);
    tick();
    tick();
    set_d(5'd11, 5'd0, 5'd12, ALU, 2'b10, 3'b000);
    chk_all("e_prio_d", 1'b0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    nop_d();
    chk_all("e_prio_e", 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0);
    tick();

    // lw $9 ; beq rs=$9 with reset during the stall: D sees empty stages after
    drain();
    set_d(5'd0, 5'd0, 5'd9, DM, 2'b00, 3'b000);
    tick();
    set_d(5'd9, 5'd9, 5'd0, NW, 2'b01, 3'b001);
    chk_all("mid_stall", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    reset = 1'b1;
    chk_all("mid_reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    reset = 1'b0;
    chk_all("after_reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
